accumulator_bank: RTL

ACCUMULATOR_BANK -- requirements
Module: accumulator_bank

---
 rtl/accumulator_pkg.sv | 36 +++
 rtl/accumulator_ram.sv | 31 +++
 rtl/accumulator_bank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/accumulator_pkg.sv
// Shared types, widths and the saturating adder used by the accumulator bank.
package accumulator_pkg;

    localparam int ACC_W = 8;
    localparam logic [1:0] MODE_8BIT = 2'b10;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_FLUSH,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic                    sat;
        logic signed [ACC_W-1:0] val;
    } sat_sum_t;

    function automatic sat_sum_t sat_add(input logic signed [ACC_W-1:0] a,
                                         input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] wide;
        sat_sum_t       r;
        wide  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // Overflow exactly when the extended sign disagrees with the result sign.
        r.sat = wide[ACC_W] ^ wide[ACC_W-1];
        if (!r.sat) begin
            r.val = wide[ACC_W-1:0];
        end else if (wide[ACC_W]) begin
            r.val = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            r.val = {1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/accumulator_ram.sv
// 1R/1W accumulator storage; read data registered one cycle after rd_en_i, held otherwise.
// No read-during-write ordering is guaranteed; the caller forwards around same-edge hazards.
module accumulator_ram #(
    parameter int ENTRY_COUNT = 16,
    parameter int ADDR_WIDTH  = $clog2(ENTRY_COUNT),
    parameter int DATA_W      = 8
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]     wr_dat_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_W-1:0]     rd_dat_o
);

    logic [DATA_W-1:0] mem_q [ENTRY_COUNT];
    logic [DATA_W-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/accumulator_bank.sv
// Saturating 8-bit accumulator bank: strobe -> RAM updated 2 cycles later, drain streams every entry.
// Writes accepted only in ACCUM; drain output holds while drain_ready is low and prefetches one entry ahead.
module accumulator_bank
    import accumulator_pkg::*;
#(
    parameter int ENTRY_COUNT = 16,
    parameter int ADDR_WIDTH  = $clog2(ENTRY_COUNT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              bitwidth,
    input  logic                    buffer_write_enable,
    input  logic [7:0]              buffer_row_write,
    input  logic [7:0]              buffer_column_write,
    input  logic signed [ACC_W-1:0] buffer_data_write,
    output logic                    bank_ready,
    input  logic                    drain_start,
    output logic                    drain_valid,
    input  logic                    drain_ready,
    output logic signed [ACC_W-1:0] drain_data,
    output logic [ADDR_WIDTH-1:0]   drain_index,
    output logic                    drain_last,
    output logic                    sat_flag,
    output logic                    drop_flag,
    output logic                    range_flag
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(ENTRY_COUNT - 1);
    localparam logic [ADDR_WIDTH:0]   FETCH_END = (ADDR_WIDTH + 1)'(ENTRY_COUNT);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
    logic                    s1_vld_q, s1_vld_d;
    logic [ADDR_WIDTH-1:0]   s1_idx_q, s1_idx_d;
    logic signed [ACC_W-1:0] s1_dat_q, s1_dat_d;
    logic                    s2_vld_q, s2_vld_d;
    logic [ADDR_WIDTH-1:0]   s2_idx_q, s2_idx_d;
    logic signed [ACC_W-1:0] s2_sum_q, s2_sum_d;
    logic [ADDR_WIDTH:0]     fetch_idx_q, fetch_idx_d;
    logic                    pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]   pend_idx_q, pend_idx_d;
    logic                    out_vld_q, out_vld_d;
    logic signed [ACC_W-1:0] out_dat_q, out_dat_d;
    logic [ADDR_WIDTH-1:0]   out_idx_q, out_idx_d;
    logic                    out_last_q, out_last_d;
    logic                    sat_q, sat_d, drop_q, drop_d, range_q, range_d;

    logic [7:0]              entry;
    logic                    mode_ok, strobe_ok, in_range, accept;
    logic                    fwd, xfer, load, issue;
    logic signed [ACC_W-1:0] operand;
    sat_sum_t                sum;
    logic                    ram_wr_en, ram_rd_en;
    logic [ADDR_WIDTH-1:0]   ram_wr_addr, ram_rd_addr;
    logic [ACC_W-1:0]        ram_wr_dat, ram_rd_dat;
    logic                    unused_dbg;

    assign unused_dbg = ^buffer_column_write;

    assign entry      = buffer_row_write >> bitwidth;
    assign mode_ok    = (bitwidth == MODE_8BIT);
    assign bank_ready = (state_q == ST_ACCUM);
    assign strobe_ok  = bank_ready && buffer_write_enable && mode_ok;
    assign in_range   = 32'(entry) < 32'(ENTRY_COUNT);
    assign accept     = strobe_ok && in_range;

    // S2 holds the sum written on the same edge as the S1 read, so RAM data is stale on a match.
    assign fwd     = s2_vld_q && (s2_idx_q == s1_idx_q);
    assign operand = fwd ? s2_sum_q : $signed(ram_rd_dat);
    assign sum     = sat_add(operand, s1_dat_q);

    assign xfer  = out_vld_q && drain_ready;
    assign load  = pend_q && (!out_vld_q || xfer);
    assign issue = (state_q == ST_DRAIN) && (fetch_idx_q < FETCH_END) && (!pend_q || load);

    always_comb begin
        ram_rd_en   = accept;
        ram_rd_addr = entry[ADDR_WIDTH-1:0];
        ram_wr_en   = s1_vld_q;
        ram_wr_addr = s1_idx_q;
        ram_wr_dat  = sum.val;
        if (state_q == ST_CLEAR) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clr_idx_q;
            ram_wr_dat  = '0;
        end else if (state_q == ST_DRAIN) begin
            ram_rd_en   = issue;
            ram_rd_addr = fetch_idx_q[ADDR_WIDTH-1:0];
            ram_wr_en   = xfer;
            ram_wr_addr = out_idx_q;
            ram_wr_dat  = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    clr_idx_d = '0;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: if (drain_start) state_d = ST_FLUSH;
            ST_FLUSH: if (!s1_vld_q && !s2_vld_q) state_d = ST_DRAIN;
            ST_DRAIN: if (xfer && out_last_q) state_d = ST_ACCUM;
            default:  state_d = ST_CLEAR;
        endcase

        s1_vld_d = accept;
        s1_idx_d = entry[ADDR_WIDTH-1:0];
        s1_dat_d = buffer_data_write;
        s2_vld_d = s1_vld_q;
        s2_idx_d = s1_idx_q;
        s2_sum_d = sum.val;

        fetch_idx_d = (state_q == ST_DRAIN) ? fetch_idx_q + (issue ? 1'b1 : 1'b0) : '0;
        pend_d      = issue ? 1'b1 : (load ? 1'b0 : pend_q);
        pend_idx_d  = issue ? fetch_idx_q[ADDR_WIDTH-1:0] : pend_idx_q;

        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        if (load) begin
            out_vld_d  = 1'b1;
            out_dat_d  = $signed(ram_rd_dat);
            out_idx_d  = pend_idx_q;
            out_last_d = (pend_idx_q == LAST_IDX);
        end else if (xfer) begin
            out_vld_d = 1'b0;
        end

        sat_d   = sat_q || (s1_vld_q && sum.sat);
        range_d = range_q || (strobe_ok && !in_range);
        drop_d  = drop_q || (buffer_write_enable && (!bank_ready || !mode_ok));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_idx_q    <= '0;
            s1_dat_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_idx_q    <= '0;
            s2_sum_q    <= '0;
            fetch_idx_q <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
            drop_q      <= 1'b0;
            range_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            s1_vld_q    <= s1_vld_d;
            s1_idx_q    <= s1_idx_d;
            s1_dat_q    <= s1_dat_d;
            s2_vld_q    <= s2_vld_d;
            s2_idx_q    <= s2_idx_d;
            s2_sum_q    <= s2_sum_d;
            fetch_idx_q <= fetch_idx_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
            drop_q      <= drop_d;
            range_q     <= range_d;
        end
    end

    accumulator_ram #(
        .ENTRY_COUNT (ENTRY_COUNT),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_W      (ACC_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_dat_i  (ram_wr_dat),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (ram_rd_addr),
        .rd_dat_o  (ram_rd_dat)
    );

    assign drain_valid = out_vld_q;
    assign drain_data  = out_dat_q;
    assign drain_index = out_idx_q;
    assign drain_last  = out_last_q;
    assign sat_flag    = sat_q;
    assign drop_flag   = drop_q;
    assign range_flag  = range_q;

endmodule
